// File: rtl/vdot_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdot_engine_pkg
// Description : Shared FSM encoding and result saturate/truncate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vdot_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    // Wide enough for any accumulator the engine can be configured with.
    localparam int c_MAXW = 256;
    typedef logic signed [c_MAXW-1:0] wide_t;

    // Clamp to a WIDTH-bit signed range when sat is set; otherwise pass the
    // value through so the caller's low-bit slice gives wrap behaviour.
    function automatic wide_t sat_trunc(input wide_t acc, input int width, input logic sat);
        wide_t w_one;
        wide_t w_hi;
        wide_t w_lo;
        wide_t w_res;
        w_one = wide_t'(1);
        w_hi  = (w_one <<< (width - 1)) - w_one;
        w_lo  = -w_hi - w_one;
        w_res = acc;
        if (sat) begin
            if (acc > w_hi) begin
                w_res = w_hi;
            end else if (acc < w_lo) begin
                w_res = w_lo;
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vdot_engine_lane_mac.sv
`default_nettype none
// ============================================================================
// Module      : vdot_lane_mac
// Description : LANES signed multipliers feeding a binary adder tree (comb.).
// Revision    : 1.0 - initial release
// ============================================================================
module vdot_lane_mac
    import vdot_engine_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 1
) (
    input  logic [LANES*WIDTH-1:0]                    aData,
    input  logic [LANES*WIDTH-1:0]                    bData,
    output logic signed [2*WIDTH+$clog2(LANES)-1:0]   sum
);

    localparam int c_PW = 2 * WIDTH;
    localparam int c_SW = 2 * WIDTH + $clog2(LANES);

    // Heap-ordered tree: leaves at LANES-1 .. 2*LANES-2, root at index 0.
    logic signed [c_SW-1:0] w_node [0:2*LANES-2];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [WIDTH-1:0] w_a;
            logic signed [WIDTH-1:0] w_b;
            logic signed [c_PW-1:0]  w_ax;
            logic signed [c_PW-1:0]  w_bx;
            logic signed [c_PW-1:0]  w_prod;

            assign w_a    = aData[i*WIDTH +: WIDTH];
            assign w_b    = bData[i*WIDTH +: WIDTH];
            assign w_ax   = c_PW'(w_a);
            assign w_bx   = c_PW'(w_b);
            assign w_prod = w_ax * w_bx;
            assign w_node[LANES-1+i] = c_SW'(w_prod);
        end

        for (genvar k = 0; k < LANES - 1; k++) begin : g_tree
            assign w_node[k] = w_node[2*k+1] + w_node[2*k+2];
        end
    endgenerate

    assign sum = w_node[0];

endmodule
`default_nettype wire

// File: rtl/vdot_engine.sv
`default_nettype none
// ============================================================================
// Module      : vdot_engine
// Description : Streaming signed dot-product engine with saturate/wrap output.
// Revision    : 1.0 - initial release
// ============================================================================
module vdot_engine
    import vdot_engine_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LENGTH = 16,
    parameter int LANES  = 1
) (
    input  logic                        Clk1,
    input  logic                        Reset,
    input  logic                        dotStart,
    input  logic                        satMode,
    output logic [$clog2(LENGTH)-1:0]   rdIdx,
    input  logic [LANES*WIDTH-1:0]      aData,
    input  logic [LANES*WIDTH-1:0]      bData,
    output logic                        busy,
    output logic                        dotWrite,
    output logic                        dotDone,
    output logic [WIDTH-1:0]            dotOut
);

    localparam int c_IW    = $clog2(LENGTH);
    localparam int c_BEATS = LENGTH / LANES;
    localparam int c_LSH   = $clog2(LANES);
    localparam int c_SW    = 2 * WIDTH + c_LSH;
    localparam int c_AW    = 2 * WIDTH + c_IW;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(c_BEATS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_IW-1:0]         r_beat;
    logic signed [c_AW-1:0]  r_acc;
    logic                    r_sat;
    logic [WIDTH-1:0]        r_dotOut;

    logic signed [c_SW-1:0]  w_lane_sum;
    logic signed [c_AW-1:0]  w_acc_sum;
    wide_t                   w_res;
    logic                    w_res_unused;

    vdot_lane_mac #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_lane_mac (
        .aData (aData),
        .bData (bData),
        .sum   (w_lane_sum)
    );

    assign w_acc_sum    = r_acc + c_AW'(w_lane_sum);
    assign w_res        = sat_trunc(c_MAXW'(w_acc_sum), WIDTH, r_sat);
    assign w_res_unused = ^w_res[c_MAXW-1:WIDTH];
    assign dotOut       = r_dotOut;

    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        dotWrite     = 1'b0;
        dotDone      = 1'b0;
        rdIdx        = '0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (dotStart) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                rdIdx = r_beat << c_LSH;
                if (r_beat == c_LAST) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                dotWrite     = 1'b1;
                dotDone      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand data lags rdIdx by a cycle, so the first RUN beat carries no
    // valid product and DRAIN collects the final one.
    always_ff @(posedge Clk1 or posedge Reset) begin
        if (Reset) begin
            r_beat   <= '0;
            r_acc    <= '0;
            r_sat    <= 1'b0;
            r_dotOut <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dotStart) begin
                        r_beat <= '0;
                        r_acc  <= '0;
                        r_sat  <= satMode;
                    end
                end
                ST_RUN: begin
                    r_beat <= (r_beat == c_LAST) ? '0 : r_beat + 1'b1;
                    if (r_beat != '0) begin
                        r_acc <= w_acc_sum;
                    end
                end
                ST_DRAIN: begin
                    r_acc    <= w_acc_sum;
                    r_dotOut <= w_res[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vdot_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdot_engine
// Description : Directed table-driven bench for vdot_engine (LANES=1 and 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdot_engine;

    logic        Clk1 = 1'b0;
    logic        Reset;
    logic        satMode;
    logic        st1, st4;
    logic [3:0]  rd1, rd4;
    logic [15:0] a1, b1;
    logic [63:0] a4, b4;
    logic        busy1, wr1, dn1, busy4, wr4, dn4;
    logic [15:0] out1, out4;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];

    int total = 0;
    int bad   = 0;
    bit wide_sel = 1'b0;

    vdot_engine #(.WIDTH(16), .LENGTH(16), .LANES(1)) u_dut1 (
        .Clk1(Clk1), .Reset(Reset), .dotStart(st1), .satMode(satMode),
        .rdIdx(rd1), .aData(a1), .bData(b1), .busy(busy1),
        .dotWrite(wr1), .dotDone(dn1), .dotOut(out1)
    );

    vdot_engine #(.WIDTH(16), .LENGTH(16), .LANES(4)) u_dut4 (
        .Clk1(Clk1), .Reset(Reset), .dotStart(st4), .satMode(satMode),
        .rdIdx(rd4), .aData(a4), .bData(b4), .busy(busy4),
        .dotWrite(wr4), .dotDone(dn4), .dotOut(out4)
    );

    always #5 Clk1 = ~Clk1;

    // Vector register file model: one-cycle read latency.
    always @(posedge Clk1) begin
        a1 <= mem_a[rd1];
        b1 <= mem_b[rd1];
        for (int i = 0; i < 4; i++) begin
            a4[i*16 +: 16] <= mem_a[rd4 + 4'(i)];
            b4[i*16 +: 16] <= mem_b[rd4 + 4'(i)];
        end
    end

    logic        c_wr, c_dn, c_busy;
    logic [15:0] c_out;
    logic [3:0]  c_rd;
    assign c_wr   = wide_sel ? wr4   : wr1;
    assign c_dn   = wide_sel ? dn4   : dn1;
    assign c_busy = wide_sel ? busy4 : busy1;
    assign c_out  = wide_sel ? out4  : out1;
    assign c_rd   = wide_sel ? rd4   : rd1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          ramp;
        bit          sat;
        bit          wide;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] av, input logic [15:0] bv, input bit ramp);
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = av;
            mem_b[i] = ramp ? 16'(i) : bv;
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge following WRITE.
    task automatic run_op(input bit wide, input bit sat, input logic [15:0] exp, input string tag);
        int beats;
        int lanes;
        int cyc;
        beats    = wide ? 4 : 16;
        lanes    = wide ? 4 : 1;
        wide_sel = wide;
        satMode  = sat;
        if (wide) st4 = 1'b1; else st1 = 1'b1;
        @(posedge Clk1); #1;
        st1 = 1'b0;
        st4 = 1'b0;
        satMode = ~sat;
        cyc = 1;
        while (c_wr !== 1'b1 && cyc < beats + 8) begin
            check({tag, " rdIdx"}, 32'(c_rd), (cyc <= beats) ? 32'((cyc - 1) * lanes) : 32'd0);
            @(posedge Clk1); #1;
            cyc++;
        end
        check({tag, " write cycle"}, 32'(cyc), 32'(beats + 2));
        check({tag, " dotDone"}, 32'(c_dn), 32'd1);
        check({tag, " dotOut"}, 32'(c_out), 32'(exp));
        @(posedge Clk1); #1;
        check({tag, " strobe drop"}, {30'd0, c_wr, c_dn}, 32'd0);
        check({tag, " hold"}, 32'(c_out), 32'(exp));
        check({tag, " idle"}, 32'(c_busy), 32'd0);
    endtask

    initial begin
        int n;
        int wcount;
        Reset   = 1'b1;
        st1     = 1'b0;
        st4     = 1'b0;
        satMode = 1'b0;
        load(16'd0, 16'd0, 1'b0);

        vecs[0]  = '{16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0078};
        vecs[1]  = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'h7FFF};
        vecs[2]  = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0, 16'h0010};
        vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'hFFF0};
        vecs[4]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'hFFF0};
        vecs[5]  = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'h8000};
        vecs[6]  = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{16'h0002, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0060};
        vecs[8]  = '{16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0078};
        vecs[9]  = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b1, 16'h0010};
        vecs[10] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b1, 16'h8000};
        vecs[11] = '{16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hFF88};

        #1;
        check("reset outs dut1", {busy1, wr1, dn1, rd1, out1}, 32'd0);
        check("reset outs dut4", {busy4, wr4, dn4, rd4, out4}, 32'd0);
        repeat (2) @(posedge Clk1);
        #1;
        Reset = 1'b0;
        @(posedge Clk1); #1;
        check("post reset idle", {30'd0, busy1, busy4}, 32'd0);

        for (int v = 0; v < 12; v++) begin
            load(vecs[v].a, vecs[v].b, vecs[v].ramp);
            run_op(vecs[v].wide, vecs[v].sat, vecs[v].exp, $sformatf("vec%0d", v));
        end

        // Start raised only during WRITE must be dropped.
        load(16'h0001, 16'h0000, 1'b1);
        wide_sel = 1'b0;
        satMode  = 1'b1;
        st1      = 1'b1;
        @(posedge Clk1); #1;
        st1 = 1'b0;
        n = 0;
        while (wr1 !== 1'b1 && n < 40) begin
            @(posedge Clk1); #1;
            n++;
        end
        check("ign write seen", 32'(wr1), 32'd1);
        st1 = 1'b1;
        @(posedge Clk1); #1;
        st1 = 1'b0;
        check("ign idle1", 32'(busy1), 32'd0);
        @(posedge Clk1); #1;
        check("ign idle2", 32'(busy1), 32'd0);

        // Reset in cycle 5 of a run aborts asynchronously.
        load(16'h0001, 16'h0000, 1'b1);
        satMode = 1'b1;
        st1     = 1'b1;
        @(posedge Clk1); #1;
        st1 = 1'b0;
        repeat (4) @(posedge Clk1);
        #1;
        check("mid run rdIdx", 32'(rd1), 32'd4);
        Reset = 1'b1;
        #1;
        check("async rst outs", {busy1, wr1, dn1, rd1, out1}, 32'd0);
        repeat (2) @(posedge Clk1);
        #1;
        Reset = 1'b0;
        wcount = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk1); #1;
            if (wr1 === 1'b1 || busy1 === 1'b1) wcount++;
        end
        check("no write after abort", 32'(wcount), 32'd0);
        run_op(1'b0, 1'b1, 16'h0078, "restart");

        // Back-to-back with dotStart held high.
        wide_sel = 1'b0;
        satMode  = 1'b1;
        st1      = 1'b1;
        n = 0;
        while (wr1 !== 1'b1 && n < 40) begin
            @(posedge Clk1); #1;
            n++;
        end
        check("b2b first write", 32'(wr1), 32'd1);
        @(posedge Clk1); #1;
        check("b2b idle gap", 32'(busy1), 32'd0);
        @(posedge Clk1); #1;
        check("b2b rerun", 32'(busy1), 32'd1);
        n = 2;
        while (wr1 !== 1'b1 && n < 40) begin
            @(posedge Clk1); #1;
            n++;
        end
        check("b2b write gap", 32'(n), 32'd19);
        check("b2b dotOut", 32'(out1), 32'h0078);
        st1 = 1'b0;
        repeat (2) begin
            @(posedge Clk1); #1;
            check("b2b stop", 32'(busy1), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
